// File: rtl/time_display_mux.sv
// Time display multiplexer: drives a 6-digit multiplexed 7-segment display (HH MM SS)
// from the binary hour, minute and second counters.
//
// Ports:
//   inclk      - clock
//   rst        - asynchronous active-high reset
//   hour_in    - hour value, valid 0..23
//   min_in     - minute value, valid 0..59
//   sec_in     - second value, valid 0..59
//   blink_mask - field blink enables {hour, minute, second}
//   seg_out    - segments {a,b,c,d,e,f,g}, active-high, registered
//   dig_sel    - one-hot digit enable (bit0 = hour tens ... bit5 = second ones), registered
//   dp_out     - colon decimal point, lit on hour ones and minute ones, registered
module time_display_mux #(
  parameter int unsigned SCAN_DIV     = 4,
  parameter int unsigned BLINK_FRAMES = 2,
  parameter int unsigned LZ_BLANK     = 0
) (
  input  logic       inclk,
  input  logic       rst,
  input  logic [5:0] hour_in,
  input  logic [5:0] min_in,
  input  logic [5:0] sec_in,
  input  logic [2:0] blink_mask,
  output logic [6:0] seg_out,
  output logic [5:0] dig_sel,
  output logic       dp_out
);

  localparam int unsigned DivW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned FrmW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(SCAN_DIV - 1);
  localparam logic [FrmW-1:0] FrmLast = FrmW'(BLINK_FRAMES - 1);

  localparam logic [6:0] SegDash  = 7'b0000001;
  localparam logic [6:0] SegBlank = 7'b0000000;

  // Binary 0..63 to {tens[2:0], ones[3:0]} by comparison ladder.
  function automatic logic [6:0] bcd_split(input logic [5:0] v);
    logic [2:0] tens;
    logic [5:0] base;
    if (v >= 6'd60) begin
      tens = 3'd6; base = 6'd60;
    end else if (v >= 6'd50) begin
      tens = 3'd5; base = 6'd50;
    end else if (v >= 6'd40) begin
      tens = 3'd4; base = 6'd40;
    end else if (v >= 6'd30) begin
      tens = 3'd3; base = 6'd30;
    end else if (v >= 6'd20) begin
      tens = 3'd2; base = 6'd20;
    end else if (v >= 6'd10) begin
      tens = 3'd1; base = 6'd10;
    end else begin
      tens = 3'd0; base = 6'd0;
    end
    return {tens, 4'(v - base)};
  endfunction

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    logic [6:0] s;
    unique case (d)
      4'd0:    s = 7'b1111110;
      4'd1:    s = 7'b0110000;
      4'd2:    s = 7'b1101101;
      4'd3:    s = 7'b1111001;
      4'd4:    s = 7'b0110011;
      4'd5:    s = 7'b1011011;
      4'd6:    s = 7'b1011111;
      4'd7:    s = 7'b1110000;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1111011;
      default: s = SegDash;
    endcase
    return s;
  endfunction

  logic [DivW-1:0] div_cnt_q, div_cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [5:0]      hour_q, hour_d, min_q, min_d, sec_q, sec_d;
  logic [FrmW-1:0] frame_cnt_q, frame_cnt_d;
  logic            blink_phase_q, blink_phase_d;
  logic [6:0]      seg_q, seg_d;
  logic [5:0]      dig_q, dig_d;
  logic            dp_q, dp_d;

  logic       tick;
  logic [5:0] field_val;
  logic [5:0] field_max;
  logic       field_blink;
  logic       field_valid;
  logic [6:0] split;
  logic [6:0] seg_n;

  // Field selection and segment decode for the digit at idx_q.
  always_comb begin
    field_val   = sec_q;
    field_max   = 6'd59;
    field_blink = blink_mask[0];
    unique case (idx_q)
      3'd0: begin
        // Frame start: hour tens shows the value being snapshotted on this edge.
        field_val   = hour_in;
        field_max   = 6'd23;
        field_blink = blink_mask[2];
      end
      3'd1: begin
        field_val   = hour_q;
        field_max   = 6'd23;
        field_blink = blink_mask[2];
      end
      3'd2, 3'd3: begin
        field_val   = min_q;
        field_blink = blink_mask[1];
      end
      default: ;
    endcase

    field_valid = (field_val <= field_max);
    split       = bcd_split(field_val);

    if (blink_phase_q && field_blink) begin
      seg_n = SegBlank;
    end else if ((LZ_BLANK != 0) && (idx_q == 3'd0) && field_valid && (split[6:4] == 3'd0)) begin
      seg_n = SegBlank;
    end else if (!field_valid) begin
      seg_n = SegDash;
    end else if (idx_q[0] == 1'b0) begin
      seg_n = seg_code({1'b0, split[6:4]});
    end else begin
      seg_n = seg_code(split[3:0]);
    end
  end

  // Next-state logic.
  always_comb begin
    tick          = (div_cnt_q == DivLast);
    div_cnt_d     = tick ? '0 : div_cnt_q + DivW'(1);
    idx_d         = idx_q;
    hour_d        = hour_q;
    min_d         = min_q;
    sec_d         = sec_q;
    frame_cnt_d   = frame_cnt_q;
    blink_phase_d = blink_phase_q;
    seg_d         = seg_q;
    dig_d         = dig_q;
    dp_d          = dp_q;

    if (tick) begin
      seg_d = seg_n;
      dig_d = 6'(1) << idx_q;
      dp_d  = (idx_q == 3'd1) || (idx_q == 3'd3);
      idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;

      if (idx_q == 3'd0) begin
        hour_d = hour_in;
        min_d  = min_in;
        sec_d  = sec_in;
      end

      if (idx_q == 3'd5) begin
        if (frame_cnt_q == FrmLast) begin
          frame_cnt_d   = '0;
          blink_phase_d = ~blink_phase_q;
        end else begin
          frame_cnt_d = frame_cnt_q + FrmW'(1);
        end
      end
    end
  end

  always_ff @(posedge inclk or posedge rst) begin
    if (rst) begin
      div_cnt_q     <= '0;
      idx_q         <= '0;
      hour_q        <= '0;
      min_q         <= '0;
      sec_q         <= '0;
      frame_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      seg_q         <= '0;
      dig_q         <= '0;
      dp_q          <= 1'b0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      idx_q         <= idx_d;
      hour_q        <= hour_d;
      min_q         <= min_d;
      sec_q         <= sec_d;
      frame_cnt_q   <= frame_cnt_d;
      blink_phase_q <= blink_phase_d;
      seg_q         <= seg_d;
      dig_q         <= dig_d;
      dp_q          <= dp_d;
    end
  end

  assign seg_out = seg_q;
  assign dig_sel = dig_q;
  assign dp_out  = dp_q;

endmodule

// File: tb/tb_time_display_mux.sv
// Directed bench for time_display_mux: scan order, frame snapshot, range dash,
// leading-zero blank, field blink and asynchronous reset.
module tb_time_display_mux;

  logic       inclk;
  logic       rst;
  logic [5:0] hour_in, min_in, sec_in;
  logic [2:0] blink_mask;
  logic [6:0] seg_out, seg_lz;
  logic [5:0] dig_sel, dig_lz;
  logic       dp_out, dp_lz;

  int total = 0;
  int bad   = 0;
  int edge_n = 0;

  time_display_mux #(
    .SCAN_DIV    (4),
    .BLINK_FRAMES(2),
    .LZ_BLANK    (0)
  ) dut (
    .inclk     (inclk),
    .rst       (rst),
    .hour_in   (hour_in),
    .min_in    (min_in),
    .sec_in    (sec_in),
    .blink_mask(blink_mask),
    .seg_out   (seg_out),
    .dig_sel   (dig_sel),
    .dp_out    (dp_out)
  );

  time_display_mux #(
    .SCAN_DIV    (4),
    .BLINK_FRAMES(2),
    .LZ_BLANK    (1)
  ) dut_lz (
    .inclk     (inclk),
    .rst       (rst),
    .hour_in   (hour_in),
    .min_in    (min_in),
    .sec_in    (sec_in),
    .blink_mask(blink_mask),
    .seg_out   (seg_lz),
    .dig_sel   (dig_lz),
    .dp_out    (dp_lz)
  );

  initial inclk = 1'b0;
  always #5 inclk = ~inclk;

  task automatic check_digit(input string tag,
                             input logic [5:0] dig_o, input logic [6:0] seg_o, input logic dp_o,
                             input logic [5:0] dig_e, input logic [6:0] seg_e, input logic dp_e);
    total++;
    assert (dig_o === dig_e) else begin
      bad++;
      $error("FAIL %s dig_sel got=%b want=%b", tag, dig_o, dig_e);
    end
    total++;
    assert (seg_o === seg_e) else begin
      bad++;
      $error("FAIL %s seg_out got=%b want=%b", tag, seg_o, seg_e);
    end
    total++;
    assert (dp_o === dp_e) else begin
      bad++;
      $error("FAIL %s dp_out got=%b want=%b", tag, dp_o, dp_e);
    end
  endtask

  // Advance to the n-th rising edge after reset release, then sample 1 time unit later.
  task automatic step_to(input int n);
    while (edge_n < n) begin
      @(posedge inclk);
      edge_n++;
    end
    #1;
  endtask

  task automatic do_reset();
    @(negedge inclk);
    rst = 1'b1;
    @(negedge inclk);
    rst = 1'b0;
    edge_n = 0;
  endtask

  initial begin
    rst        = 1'b1;
    hour_in    = 6'd13;
    min_in     = 6'd45;
    sec_in     = 6'd7;
    blink_mask = 3'b000;

    // Outputs held at zero while reset is asserted across clock edges.
    repeat (3) @(posedge inclk);
    #1;
    check_digit("reset_hold", dig_sel, seg_out, dp_out, 6'b000000, 7'b0000000, 1'b0);

    // Basic scan of 13:45:07, with hour_in changing mid-frame.
    @(negedge inclk);
    rst = 1'b0;
    edge_n = 0;
    step_to(3);
    check_digit("pre_first", dig_sel, seg_out, dp_out, 6'b000000, 7'b0000000, 1'b0);
    step_to(4);
    check_digit("scan_d0", dig_sel, seg_out, dp_out, 6'b000001, 7'b0110000, 1'b0);
    step_to(8);
    check_digit("scan_d1", dig_sel, seg_out, dp_out, 6'b000010, 7'b1111001, 1'b1);
    step_to(10);
    hour_in = 6'd22;
    step_to(12);
    check_digit("scan_d2", dig_sel, seg_out, dp_out, 6'b000100, 7'b0110011, 1'b0);
    step_to(16);
    check_digit("scan_d3", dig_sel, seg_out, dp_out, 6'b001000, 7'b1011011, 1'b1);
    step_to(20);
    check_digit("scan_d4", dig_sel, seg_out, dp_out, 6'b010000, 7'b1111110, 1'b0);
    step_to(24);
    check_digit("scan_d5", dig_sel, seg_out, dp_out, 6'b100000, 7'b1110000, 1'b0);
    step_to(28);
    check_digit("tear_d0", dig_sel, seg_out, dp_out, 6'b000001, 7'b1101101, 1'b0);
    step_to(32);
    check_digit("tear_d1", dig_sel, seg_out, dp_out, 6'b000010, 7'b1101101, 1'b1);

    // Out-of-range hour and minute show dashes; leading-zero blank does not apply.
    hour_in = 6'd24;
    min_in  = 6'd60;
    sec_in  = 6'd59;
    do_reset();
    step_to(4);
    check_digit("range_d0", dig_sel, seg_out, dp_out, 6'b000001, 7'b0000001, 1'b0);
    check_digit("range_lz_d0", dig_lz, seg_lz, dp_lz, 6'b000001, 7'b0000001, 1'b0);
    step_to(8);
    check_digit("range_d1", dig_sel, seg_out, dp_out, 6'b000010, 7'b0000001, 1'b1);
    step_to(12);
    check_digit("range_d2", dig_sel, seg_out, dp_out, 6'b000100, 7'b0000001, 1'b0);
    step_to(16);
    check_digit("range_d3", dig_sel, seg_out, dp_out, 6'b001000, 7'b0000001, 1'b1);
    step_to(20);
    check_digit("range_d4", dig_sel, seg_out, dp_out, 6'b010000, 7'b1011011, 1'b0);
    step_to(24);
    check_digit("range_d5", dig_sel, seg_out, dp_out, 6'b100000, 7'b1111011, 1'b0);

    // Leading zero: hour 05.
    hour_in = 6'd5;
    min_in  = 6'd0;
    sec_in  = 6'd0;
    do_reset();
    step_to(4);
    check_digit("lz_d0", dig_lz, seg_lz, dp_lz, 6'b000001, 7'b0000000, 1'b0);
    check_digit("nolz_d0", dig_sel, seg_out, dp_out, 6'b000001, 7'b1111110, 1'b0);
    step_to(8);
    check_digit("lz_d1", dig_lz, seg_lz, dp_lz, 6'b000010, 7'b1011011, 1'b1);

    // Minute field blink; frame f digit k appears at edge 4 + 24*f + 4*k.
    hour_in    = 6'd13;
    min_in     = 6'd45;
    sec_in     = 6'd7;
    blink_mask = 3'b010;
    do_reset();
    step_to(36);
    check_digit("blink_f1_d2", dig_sel, seg_out, dp_out, 6'b000100, 7'b0110011, 1'b0);
    step_to(52);
    check_digit("blink_f2_d0", dig_sel, seg_out, dp_out, 6'b000001, 7'b0110000, 1'b0);
    step_to(60);
    check_digit("blink_f2_d2", dig_sel, seg_out, dp_out, 6'b000100, 7'b0000000, 1'b0);
    step_to(64);
    check_digit("blink_f2_d3", dig_sel, seg_out, dp_out, 6'b001000, 7'b0000000, 1'b1);
    step_to(68);
    check_digit("blink_f2_d4", dig_sel, seg_out, dp_out, 6'b010000, 7'b1111110, 1'b0);
    step_to(84);
    check_digit("blink_f3_d2", dig_sel, seg_out, dp_out, 6'b000100, 7'b0000000, 1'b0);
    step_to(108);
    check_digit("blink_f4_d2", dig_sel, seg_out, dp_out, 6'b000100, 7'b0110011, 1'b0);
    step_to(112);
    check_digit("blink_f4_d3", dig_sel, seg_out, dp_out, 6'b001000, 7'b1011011, 1'b1);

    // Asynchronous reset mid-scan (idx = 3), away from any clock edge.
    blink_mask = 3'b000;
    do_reset();
    step_to(14);
    check_digit("pre_async", dig_sel, seg_out, dp_out, 6'b000100, 7'b0110011, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check_digit("async_rst", dig_sel, seg_out, dp_out, 6'b000000, 7'b0000000, 1'b0);
    @(negedge inclk);
    rst = 1'b0;
    edge_n = 0;
    step_to(3);
    check_digit("post_async_e3", dig_sel, seg_out, dp_out, 6'b000000, 7'b0000000, 1'b0);
    step_to(4);
    check_digit("post_async_e4", dig_sel, seg_out, dp_out, 6'b000001, 7'b0110000, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
